// File: rtl/vga_frame_reader_pkg.sv
// Shared VGA 640x480@60 timing constants and pixel layout for capture, reader and frame buffer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_frame_reader_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP; // 800

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP; // 525

    // One word per visible pixel; addresses run 0..FB_DEPTH-1.
    localparam int FB_DEPTH = VGA_H_ACTIVE * VGA_V_ACTIVE; // 307200
    // pclk cycles from counter position to the vga_* pins.
    localparam int PIPE_LAT = 2;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 12;
    localparam int CNT_W  = 10;

    // Frame-buffer word layout: {r, g, b}, 4 bits each.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA pin bundle between the reader and its surroundings.
// Latency: n/a (wiring only); rd_data is expected one pclk after rd_addr.
// Backpressure: none; the reader streams continuously at the pixel rate.
interface vga_frame_reader_if;
    import vga_frame_reader_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              vga_hs;
    logic              vga_vs;
    logic              frame_start;

    // Reader side: issues addresses, consumes pixels, drives the pins.
    modport master (
        output rd_addr,
        input  rd_data,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output frame_start
    );

    // Memory/display side.
    modport slave (
        input  rd_addr,
        output rd_data,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  frame_start
    );

endinterface

// File: rtl/vga_frame_reader_timing.sv
// Horizontal/vertical pixel counters with raw active-video and active-low sync qualifiers.
// Latency: qualifiers are combinational from the registered counters (0 pclk).
// Backpressure: none; counters free-run every pclk.
module vga_timing
    import vga_frame_reader_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic pclk,
    input  logic reset_n,
    output logic active,
    output logic hsync_raw,
    output logic vsync_raw,
    output logic at_origin,
    output logic last_pos
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;

    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Raster position: h wraps every line, v steps on each h wrap and wraps at frame end.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hsync_raw = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END)));
    assign vsync_raw = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END)));
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    // Next position is (0,0).
    assign last_pos  = h_last && v_last;

endmodule

// File: rtl/vga_frame_reader.sv
// Streams a frame buffer to VGA pins: address generation, qualifier delay and colour/sync registers.
// Latency: 2 pclk from counter position to vga_* pins (1 for the RAM read, 1 output register).
// Backpressure: none; one address per pclk, rd_data must follow one pclk after rd_addr.
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic                pclk,
    input  logic                reset_n,
    vga_frame_reader_if.master  bus
);

    // Last valid word; the address saturates here instead of running past the buffer.
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic              active;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              at_origin;
    logic              last_pos;

    logic [ADDR_W-1:0] addr_q;
    logic              act_d1;
    logic              hs_d1;
    logic              vs_d1;
    logic              org_d1;
    logic [3:0]        r_q;
    logic [3:0]        g_q;
    logic [3:0]        b_q;
    logic              hs_q;
    logic              vs_q;
    logic              fs_q;
    pixel_t            pix;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .active    (active),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .at_origin (at_origin),
        .last_pos  (last_pos)
    );

    // Incremental address: tracks v*H_ACTIVE+h while active, holds in blanking, zero at frame wrap.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (last_pos) begin
            addr_q <= '0;
        end else if (active && (addr_q != ADDR_MAX)) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    assign bus.rd_addr = addr_q;

    // First pipeline stage: qualifiers wait alongside the RAM read.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            act_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
            org_d1 <= 1'b0;
        end else begin
            act_d1 <= active;
            hs_d1  <= hsync_raw;
            vs_d1  <= vsync_raw;
            org_d1 <= at_origin;
        end
    end

    assign pix = pixel_t'(bus.rd_data);

    // Output stage: colour only while delayed-active, otherwise black; syncs and frame pulse follow.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_q  <= 4'h0;
            g_q  <= 4'h0;
            b_q  <= 4'h0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            fs_q <= 1'b0;
        end else begin
            r_q  <= act_d1 ? pix.r : 4'h0;
            g_q  <= act_d1 ? pix.g : 4'h0;
            b_q  <= act_d1 ? pix.b : 4'h0;
            hs_q <= hs_d1;
            vs_q <= vs_d1;
            fs_q <= org_d1;
        end
    end

    assign bus.vga_r       = r_q;
    assign bus.vga_g       = g_q;
    assign bus.vga_b       = b_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: full-size reader for line timing, addressing, pixel data and mid-frame reset;
// a shrunken-geometry reader (25x19 raster) for whole-frame vertical timing and address saturation.
// Both frame-buffer models answer one pclk after the address.
module tb_vga_frame_reader;
    import vga_frame_reader_pkg::*;

    logic pclk = 1'b0;
    logic reset_n;
    logic reset_s_n;
    logic ff_mode;
    int   n;
    int   checks = 0;
    int   errors = 0;
    int   fs_count;

    always #20 pclk = ~pclk;

    vga_frame_reader_if bus_d ();
    vga_frame_reader_if bus_s ();

    vga_frame_reader u_dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus_d.master)
    );

    vga_frame_reader #(
        .H_ACTIVE (16),
        .H_FP     (2),
        .H_SYNC   (4),
        .H_BP     (3),
        .V_ACTIVE (12),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) u_small (
        .pclk    (pclk),
        .reset_n (reset_s_n),
        .bus     (bus_s.master)
    );

    // Frame-buffer models: word = low 12 address bits, except address 0 holds 12'hA5C.
    always @(posedge pclk) begin
        bus_d.rd_data <= ff_mode ? 12'hFFF
                       : ((bus_d.rd_addr == '0) ? 12'hA5C : bus_d.rd_addr[11:0]);
        bus_s.rd_data <= (bus_s.rd_addr == '0) ? 12'hA5C : bus_s.rd_addr[11:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        n++;
    endtask

    // Expected address at counter position q (cycles since frame start).
    function automatic logic [31:0] e_addr(int q, int ht, int ha, int vt, int va);
        int h, v, t;
        q = q % (ht * vt);
        h = q % ht;
        v = q / ht;
        if (v >= va) return ha * va - 1;
        if (h < ha)  return v * ha + h;
        t = (v + 1) * ha;
        if (t > ha * va - 1) t = ha * va - 1;
        return t;
    endfunction

    function automatic logic e_hs(int c, int ht, int vt, int s0, int sl);
        int h;
        if (c < 2) return 1'b1;
        h = ((c - 2) % (ht * vt)) % ht;
        return !((h >= s0) && (h < s0 + sl));
    endfunction

    function automatic logic e_vs(int c, int ht, int vt, int s0, int sl);
        int v;
        if (c < 2) return 1'b1;
        v = ((c - 2) % (ht * vt)) / ht;
        return !((v >= s0) && (v < s0 + sl));
    endfunction

    function automatic logic e_fs(int c, int ht, int vt);
        return (c >= 2) && (((c - 2) % (ht * vt)) == 0);
    endfunction

    // Pins at cycle c show position c-2; positions from fff_from on were read as 12'hFFF.
    function automatic logic [31:0] e_pix(int c, int ht, int ha, int vt, int va, int fff_from);
        int p, q, h, v, a;
        if (c < 2) return 0;
        p = c - 2;
        q = p % (ht * vt);
        h = q % ht;
        v = q / ht;
        if (!((h < ha) && (v < va))) return 0;
        if (p >= fff_from) return 32'hFFF;
        a = v * ha + h;
        if (a == 0) return 32'hA5C;
        return {20'h0, a[11:0]};
    endfunction

    task automatic chk_reset_d();
        chk("d_rst_addr", bus_d.rd_addr, 0);
        chk("d_rst_pix", {bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}, 0);
        chk("d_rst_hs", bus_d.vga_hs, 1);
        chk("d_rst_vs", bus_d.vga_vs, 1);
        chk("d_rst_fs", bus_d.frame_start, 0);
    endtask

    // Per-cycle checks of the full-size reader for cycles 0..ncyc-1 after reset release.
    task automatic run_default(input int ncyc);
        while (n < ncyc) begin
            chk("d_addr", bus_d.rd_addr, e_addr(n, 800, 640, 525, 480));
            chk("d_pix", {bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}, e_pix(n, 800, 640, 525, 480, 800));
            chk("d_hs", bus_d.vga_hs, e_hs(n, 800, 525, 656, 96));
            chk("d_vs", bus_d.vga_vs, e_vs(n, 800, 525, 490, 2));
            chk("d_fs", bus_d.frame_start, e_fs(n, 800, 525));
            if (n == 2)    chk("d_fs_at2_rgb", {bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}, 32'hA5C);
            if (n == 639)  chk("d_addr_639", bus_d.rd_addr, 639);
            if (n == 700)  chk("d_addr_hold", bus_d.rd_addr, 640);
            if (n == 800)  chk("d_addr_640", bus_d.rd_addr, 640);
            if (n == 658)  chk("d_hs_first_low", bus_d.vga_hs, 0);
            if (n == 754)  chk("d_hs_back_high", bus_d.vga_hs, 1);
            if (n == 1458) chk("d_hs_second_low", bus_d.vga_hs, 0);
            if (n == 800)  ff_mode = 1'b1;
            tick();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_s_n = 1'b0;
        ff_mode   = 1'b0;
        n         = 0;
        repeat (3) @(posedge pclk);
        #1;
        chk_reset_d();
        chk("s_rst_addr", bus_s.rd_addr, 0);
        chk("s_rst_hs", bus_s.vga_hs, 1);
        chk("s_rst_vs", bus_s.vga_vs, 1);

        // First frame of the full-size reader, up to position (300,2).
        reset_n = 1'b1;
        n = 0;
        run_default(1900);
        chk("d_addr_300_2", bus_d.rd_addr, 2 * 640 + 300);

        // Mid-frame reset: outputs go to reset values without waiting for a clock.
        reset_n = 1'b0;
        #1;
        chk_reset_d();
        ff_mode = 1'b0;
        repeat (5) @(posedge pclk);
        #1;
        chk_reset_d();

        // After release the sequence must repeat the first-frame one exactly.
        reset_n = 1'b1;
        n = 0;
        run_default(1700);

        // Shrunken raster: two full frames plus a bit (frame = 25*19 = 475 cycles).
        reset_s_n = 1'b1;
        n = 0;
        fs_count = 0;
        while (n < 1000) begin
            chk("s_addr", bus_s.rd_addr, e_addr(n, 25, 16, 19, 12));
            chk("s_pix", {bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}, e_pix(n, 25, 16, 19, 12, 32'h4000_0000));
            chk("s_hs", bus_s.vga_hs, e_hs(n, 25, 19, 18, 4));
            chk("s_vs", bus_s.vga_vs, e_vs(n, 25, 19, 14, 2));
            chk("s_fs", bus_s.frame_start, e_fs(n, 25, 19));
            if (bus_s.frame_start) fs_count++;
            if (n == 290) chk("s_addr_max", bus_s.rd_addr, 191);
            if (n == 400) chk("s_addr_held", bus_s.rd_addr, 191);
            if (n == 475) chk("s_addr_wrap", bus_s.rd_addr, 0);
            if (n == 352) chk("s_vs_first_low", bus_s.vga_vs, 0);
            if (n == 827) chk("s_vs_second_low", bus_s.vga_vs, 0);
            if (n == 402) chk("s_vs_back_high", bus_s.vga_vs, 1);
            tick();
        end
        chk("s_fs_count", fs_count, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
